dbg_scan_sched: RTL and testbench

- Scheduler for the debug display path of the single-cycle CPU board top.
- Generates a slow scan tick from clk and walks the address space of one selected debug source: instruction ROM, register file, ALU snapshot or data memory.
- Issues one read per tick over a shared req/ack debug read port and latches the result as the 32-bit word for the 7-segment driver.
- Inserts an all-ones separator frame at each wrap.

---
 rtl/dbg_scan_sched_if.sv | 11 +
 rtl/dbg_scan_sched.sv | 146 ++++++++++++++
 tb/tb_dbg_scan_sched.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_scan_sched_if.sv
// Shared debug read port between the display scan scheduler and the debug sources.
interface dbg_scan_sched_if;
    logic        rd_req;
    logic [1:0]  rd_src;
    logic [5:0]  rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;

    modport master (output rd_req, rd_src, rd_addr, input rd_ack, rd_data);
    modport slave  (input rd_req, rd_src, rd_addr, output rd_ack, rd_data);
endinterface

// File: rtl/dbg_scan_sched.sv
// Debug display scan scheduler: walks one debug source per scan tick and latches
// each read word (or a separator / timeout marker) for the 7-segment driver.
module dbg_scan_sched #(
    parameter int FAST_BIT    = 25,
    parameter int SLOW_BIT    = 27,
    parameter int ROM_DEPTH   = 12,
    parameter int RF_DEPTH    = 8,
    parameter int ALU_DEPTH   = 4,
    parameter int DM_DEPTH    = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [3:0]             src_sel,
    input  logic                   slow,
    input  logic                   freeze,
    input  logic                   step,
    dbg_scan_sched_if.master       rd,
    output logic [31:0]            disp_data,
    output logic                   disp_valid,
    output logic [5:0]             cur_addr,
    output logic                   timeout_err
);

    localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    state_t              state_reg;
    logic [SLOW_BIT:0]   div_reg;
    logic                tick_q_reg;
    logic                step_q_reg;
    logic [5:0]          addr_reg;
    logic [3:0]          src_q_reg;
    logic [WAIT_W-1:0]   wait_reg;
    logic                rd_req_reg;
    logic [1:0]          rd_src_reg;
    logic [5:0]          rd_addr_reg;
    logic [31:0]         disp_data_reg;
    logic                disp_valid_reg;
    logic                timeout_err_reg;

    logic                tick_bit;
    logic                tick;
    logic                step_pulse;
    logic                go;
    logic                src_valid;
    logic [5:0]          depth;
    logic [1:0]          src_enc;

    assign tick_bit   = slow ? div_reg[SLOW_BIT] : div_reg[FAST_BIT];
    assign tick       = tick_bit & ~tick_q_reg;
    assign step_pulse = step & ~step_q_reg;
    assign go         = (tick & ~freeze) | step_pulse;
    assign src_valid  = ($countones(src_q_reg) == 1);

    always_comb begin
        depth   = '0;
        src_enc = 2'd0;
        case (src_q_reg)
            4'b1000: begin depth = 6'(ROM_DEPTH); src_enc = 2'd3; end
            4'b0100: begin depth = 6'(RF_DEPTH);  src_enc = 2'd2; end
            4'b0010: begin depth = 6'(ALU_DEPTH); src_enc = 2'd1; end
            4'b0001: begin depth = 6'(DM_DEPTH);  src_enc = 2'd0; end
            default: begin depth = '0;            src_enc = 2'd0; end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= ST_IDLE;
            div_reg         <= '0;
            tick_q_reg      <= 1'b0;
            step_q_reg      <= 1'b0;
            addr_reg        <= '0;
            src_q_reg       <= '0;
            wait_reg        <= '0;
            rd_req_reg      <= 1'b0;
            rd_src_reg      <= '0;
            rd_addr_reg     <= '0;
            disp_data_reg   <= '0;
            disp_valid_reg  <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            div_reg        <= div_reg + 1'b1;
            tick_q_reg     <= tick_bit;
            step_q_reg     <= step;
            disp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // A source change owns this cycle; any coincident go is dropped.
                    if (src_sel != src_q_reg) begin
                        src_q_reg      <= src_sel;
                        addr_reg       <= '0;
                        disp_data_reg  <= '0;
                        disp_valid_reg <= 1'b1;
                    end else if (go) begin
                        if (!src_valid) begin
                            disp_data_reg <= '0;
                        end else if (addr_reg == depth) begin
                            disp_data_reg  <= 32'hFFFF_FFFF;
                            disp_valid_reg <= 1'b1;
                            addr_reg       <= '0;
                        end else begin
                            rd_req_reg  <= 1'b1;
                            rd_src_reg  <= src_enc;
                            rd_addr_reg <= addr_reg;
                            wait_reg    <= '0;
                            state_reg   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack is checked first so a last-cycle ack still delivers data.
                    if (rd.rd_ack) begin
                        disp_data_reg  <= rd.rd_data;
                        disp_valid_reg <= 1'b1;
                        addr_reg       <= addr_reg + 1'b1;
                        rd_req_reg     <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end else if (wait_reg == WAIT_LAST) begin
                        disp_data_reg   <= 32'hDEAD_DEAD;
                        disp_valid_reg  <= 1'b1;
                        timeout_err_reg <= 1'b1;
                        addr_reg        <= addr_reg + 1'b1;
                        rd_req_reg      <= 1'b0;
                        state_reg       <= ST_IDLE;
                    end else begin
                        wait_reg <= wait_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign rd.rd_req   = rd_req_reg;
    assign rd.rd_src   = rd_src_reg;
    assign rd.rd_addr  = rd_addr_reg;
    assign disp_data   = disp_data_reg;
    assign disp_valid  = disp_valid_reg;
    assign cur_addr    = addr_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_dbg_scan_sched.sv
// Directed bench for dbg_scan_sched: scenario table plus hand-written corner sequences.
module tb_dbg_scan_sched;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  src_sel = 4'b0000;
    logic        slow = 1'b0;
    logic        freeze = 1'b0;
    logic        step = 1'b0;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic [5:0]  cur_addr;
    logic        timeout_err;

    dbg_scan_sched_if rd_if();

    dbg_scan_sched #(
        .FAST_BIT(2), .SLOW_BIT(4), .ROM_DEPTH(12), .RF_DEPTH(8),
        .ALU_DEPTH(4), .DM_DEPTH(16), .ACK_TIMEOUT(15)
    ) dut (
        .clk(clk), .rstn(rstn), .src_sel(src_sel), .slow(slow),
        .freeze(freeze), .step(step), .rd(rd_if),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .cur_addr(cur_addr), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Responder configuration
    bit          ack_en = 1'b1;
    int          ack_delay = 2;
    logic [31:0] data_base = '0;

    // Monitor logs
    int  req_addr_log[$];
    int  req_src_log[$];
    int  req_cyc_log[$];
    int  disp_log[$];
    int  req_high = 0;
    bit  req_prev = 1'b0;

    always @(posedge clk) begin
        if (!rstn) cyc = 0;
        else       cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (rd_if.rd_req && !req_prev) begin
            req_addr_log.push_back(int'(rd_if.rd_addr));
            req_src_log.push_back(int'(rd_if.rd_src));
            req_cyc_log.push_back(cyc);
            $display("  req  cyc=%0d src=%0d addr=%0d", cyc, rd_if.rd_src, rd_if.rd_addr);
        end
        req_prev = rd_if.rd_req;
        if (rd_if.rd_req) req_high = req_high + 1;
        if (disp_valid) disp_log.push_back(int'(disp_data));
    end

    initial begin
        int age;
        age = 0;
        rd_if.rd_ack  = 1'b0;
        rd_if.rd_data = '0;
        forever begin
            @(negedge clk);
            if (rd_if.rd_req) begin
                age = age + 1;
                if (ack_en && age == ack_delay) begin
                    rd_if.rd_ack  = 1'b1;
                    rd_if.rd_data = data_base + 32'(rd_if.rd_addr) * 32'h11;
                end else begin
                    rd_if.rd_ack = 1'b0;
                end
            end else begin
                age = 0;
                rd_if.rd_ack = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic start(input logic [3:0] s, input logic slw, input logic frz);
        rstn = 1'b0;
        src_sel = s; slow = slw; freeze = frz; step = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        req_addr_log.delete(); req_src_log.delete(); req_cyc_log.delete(); disp_log.delete();
        req_high = 0; req_prev = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    typedef struct {
        logic [3:0] src;
        logic       slw;
        logic       frz;
        int         cycles;
        int         exp_reqs;
        int         exp_first;
        int         exp_gap;
        int         exp_src;
    } scen_t;

    scen_t tbl[5];

    initial begin
        int n, first, gap, src0, n_disp, n_req;
        bit found;

        tbl[0] = '{4'b0100, 1'b0, 1'b0, 60, 7, 5, 8, 2};    // RF fast tick
        tbl[1] = '{4'b0100, 1'b1, 1'b0, 60, 2, 17, 32, 2};  // RF slow tick
        tbl[2] = '{4'b0110, 1'b0, 1'b0, 60, 0, -1, -1, -1}; // two bits set
        tbl[3] = '{4'b0100, 1'b0, 1'b1, 60, 0, -1, -1, -1}; // frozen, no steps
        tbl[4] = '{4'b1000, 1'b0, 1'b0, 60, 7, 5, 8, 3};    // ROM fast tick

        // Reset state
        src_sel = 4'b0100;
        repeat (2) @(negedge clk);
        check("rst_rd_req", 32'(rd_if.rd_req), 0);
        check("rst_rd_src", 32'(rd_if.rd_src), 0);
        check("rst_rd_addr", 32'(rd_if.rd_addr), 0);
        check("rst_disp_data", disp_data, 0);
        check("rst_disp_valid", 32'(disp_valid), 0);
        check("rst_cur_addr", 32'(cur_addr), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);

        // Scenario table
        for (int i = 0; i < 5; i++) begin
            ack_en = 1'b1; ack_delay = 2; data_base = '0;
            start(tbl[i].src, tbl[i].slw, tbl[i].frz);
            repeat (tbl[i].cycles) @(negedge clk);
            #1;
            n     = req_cyc_log.size();
            first = (n > 0) ? req_cyc_log[0] : -1;
            gap   = (n > 1) ? req_cyc_log[1] - req_cyc_log[0] : -1;
            src0  = (n > 0) ? req_src_log[0] : -1;
            check($sformatf("scen%0d_reqs", i), n, tbl[i].exp_reqs);
            check($sformatf("scen%0d_first", i), first, tbl[i].exp_first);
            check($sformatf("scen%0d_gap", i), gap, tbl[i].exp_gap);
            check($sformatf("scen%0d_src", i), src0, tbl[i].exp_src);
        end

        // Full RF pass: source-change clear, 8 reads, separator, restart at 0
        ack_en = 1'b1; ack_delay = 2; data_base = '0;
        start(4'b0100, 1'b0, 1'b0);
        repeat (82) @(negedge clk);
        #1;
        check("rf_disp_count", disp_log.size(), 11);
        check("rf_req_count", req_addr_log.size(), 9);
        if (disp_log.size() == 11) begin
            check("rf_disp_clear", disp_log[0], 0);
            for (int k = 0; k < 8; k++)
                check($sformatf("rf_disp%0d", k), disp_log[k+1], k * 32'h11);
            check("rf_separator", disp_log[9], 32'hFFFF_FFFF);
            check("rf_disp_wrap", disp_log[10], 0);
        end
        if (req_addr_log.size() == 9) begin
            for (int k = 0; k < 8; k++)
                check($sformatf("rf_addr%0d", k), req_addr_log[k], k);
            check("rf_addr_wrap", req_addr_log[8], 0);
        end

        // ROM with no ack: timeout after exactly 15 request cycles
        ack_en = 1'b0;
        start(4'b1000, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        #1;
        check("to_req_cycles", req_high, 15);
        check("to_req_dropped", 32'(rd_if.rd_req), 0);
        check("to_err", 32'(timeout_err), 1);
        check("to_disp", disp_data, 32'hDEAD_DEAD);
        check("to_cur_addr", 32'(cur_addr), 1);

        // Ack lands in the timeout cycle: data wins, no error
        ack_en = 1'b1; ack_delay = 15; data_base = 32'h1000;
        start(4'b1000, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        #1;
        check("race_req_cycles", req_high, 15);
        check("race_disp", disp_data, 32'h1000);
        check("race_err", 32'(timeout_err), 0);
        check("race_cur_addr", 32'(cur_addr), 1);

        // Frozen ALU scan driven by three step edges, step held high between
        ack_en = 1'b1; ack_delay = 2; data_base = '0;
        start(4'b0010, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            repeat (6) @(negedge clk);
            step = 1'b1;
            repeat (12) @(negedge clk);
            step = 1'b0;
        end
        repeat (40) @(negedge clk);
        #1;
        check("step_reqs", req_addr_log.size(), 3);
        if (req_addr_log.size() == 3) begin
            for (int k = 0; k < 3; k++)
                check($sformatf("step_addr%0d", k), req_addr_log[k], k);
            check("step_src", req_src_log[0], 1);
        end

        // Switch RF->DM while the addr 5 read is outstanding
        ack_en = 1'b1; ack_delay = 4; data_base = '0;
        start(4'b0100, 1'b0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            #1;
            if (rd_if.rd_req && rd_if.rd_addr == 6'd5) found = 1'b1;
        end
        check("sw_found_addr5", 32'(found), 1);
        n_disp = disp_log.size();
        n_req  = req_addr_log.size();
        src_sel = 4'b0001;
        for (int k = 0; k < 100 && req_addr_log.size() <= n_req; k++) @(negedge clk);
        #1;
        check("sw_next_req_seen", 32'(req_addr_log.size() > n_req), 1);
        if (req_addr_log.size() > n_req && disp_log.size() >= n_disp + 2) begin
            check("sw_rf_done", disp_log[n_disp], 32'h55);
            check("sw_clear", disp_log[n_disp+1], 0);
            check("sw_new_src", req_src_log[n_req], 0);
            check("sw_new_addr", req_addr_log[n_req], 0);
        end

        // Asynchronous reset in the middle of a request
        ack_en = 1'b1; ack_delay = 2; data_base = '0;
        start(4'b0100, 1'b0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            #1;
            if (rd_if.rd_req && rd_if.rd_addr == 6'd2) found = 1'b1;
        end
        check("ar_found_addr2", 32'(found), 1);
        check("ar_disp_before", disp_data, 32'h11);
        #1 rstn = 1'b0;
        #1;
        check("ar_rd_req", 32'(rd_if.rd_req), 0);
        check("ar_disp", disp_data, 0);
        check("ar_cur_addr", 32'(cur_addr), 0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
